eth_rx_mac_filter: RTL
======================

# eth_rx_mac_filter

Destination-MAC filter on the 8-bit receive AXI-Stream, at 125 MHz, directly downstream of the RGMII Ethernet MAC's RX_AXIS port and upstream of the DMA. It buffers the 6-byte destination address of each frame and decides whether to keep it. Accepted frames are forwarded unchanged, with the header replayed ahead of the payload. Rejected and runt frames are drained upstream and never appear downstream.

## Interface
Parameters:
- CNT_WIDTH, 32, width of the pass/drop statistics counters.

Ports (one clock, `clock125`; reset `reset` is asynchronous and active-high):
- clock125  in  1  125 MHz clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tdata / tkeep / tvalid / tlast / tuser  in  8/1/1/1/1  frame stream from the MAC.
- s_axis_tready  out  1  ready to the MAC.
- m_axis_tdata / tkeep / tvalid / tlast / tuser  out  8/1/1/1/1  filtered stream.
- m_axis_tready  in  1  downstream ready.
- mac_addr  in  48  station address; first wire byte = mac_addr[47:40]; quasi-static.
- promisc  in  1  accept every frame of 7 bytes or more.
- accept_broadcast  in  1  accept destination FF:FF:FF:FF:FF:FF.
- accept_multicast  in  1  accept a destination whose I/G bit (bit 0 of first byte) is 1.
- pass_count  out  CNT_WIDTH  frames accepted, saturating.
- drop_count  out  CNT_WIDTH  frames rejected, including runts, saturating.

## Operation
- States:
  - IDLE: waiting for the first byte of a frame.
  - HDR: collecting header bytes 0..5.
  - REPLAY: emitting the 6 buffered header bytes downstream.
  - PASS: forwarding the rest of an accepted frame.
  - DROP: discarding the rest of a rejected frame.
- IDLE: s_axis_tready=1. On the first beat, store byte 0, set hdr_idx=1 and go to HDR.
- HDR: s_axis_tready=1. Store each beat at hdr_idx.
  - tlast on any header byte 0..5: runt. Increment drop_count and go to IDLE. The frame never appears downstream.
  - 6th byte accepted without tlast: decide in the same cycle.
- Accept rule, evaluated in this priority order: promisc; dest==mac_addr; dest==all-ones and accept_broadcast; I/G=1 and accept_multicast. Broadcast that fails the broadcast rule can still pass through the multicast rule.
- Accept: increment pass_count and go to REPLAY. Reject: increment drop_count and go to DROP.
- REPLAY:
  - s_axis_tready=0.
  - m_axis_tvalid=1, tdata=hdr[idx], tkeep=1, tlast=0, tuser=0.
  - idx advances only on m_axis_tready. After byte 5 is taken, go to PASS.
- PASS:
  - Combinational pass-through: m_axis_* = s_axis_*, s_axis_tready = m_axis_tready.
  - On a transfer with tlast, go to IDLE.
  - tuser (bad-frame marker) is propagated untouched.
- DROP: s_axis_tready=1 and m_axis_tvalid=0. On an accepted tlast, go to IDLE.
- Counters saturate at all-ones and never wrap.
- Filter controls are sampled only in the decision cycle. A change mid-frame affects the next frame only.

## Timing
- Reset values: state=IDLE, hdr_idx=0, header buffer=0, counters=0.
- Outputs under reset: m_axis_tvalid=0, tdata=0, tlast=0, tuser=0, tkeep=0, s_axis_tready=0.
- s_axis_tready rises the first cycle after reset deasserts.
- Latency: the first downstream byte is valid in the cycle after the 6th header byte is accepted. Each frame adds 6 upstream-stall cycles when m_axis_tready=1.
- Throughput: 1 byte/cycle in PASS, IDLE, HDR and DROP. There is no bubble between back-to-back frames (tlast in PASS/DROP → IDLE, next beat accepted the following cycle).
- AXIS rules:
  - m_axis_tvalid, once asserted, holds with stable data until m_axis_tready.
  - tvalid never depends on tready.
- Reset mid-frame: immediate return to IDLE with partial output abandoned. The MAC shares `reset`, so no stale tail arrives afterwards.

## Configuration
- ETH_RX_FILTER_STATS_EN defined: pass_count and drop_count registers are present as above.
- Undefined: both outputs are tied to 0 and the counter logic is removed. Filtering behaviour is identical.

## Structure
- Package eth_rx_filter_pkg holds:
  - state enum {IDLE, HDR, REPLAY, PASS, DROP};
  - localparam HDR_BYTES=6;
  - localparam MAC_BCAST=48'hFFFF_FFFF_FFFF.
- Sub-module eth_rx_mac_match: combinational. Takes the 48-bit dest, mac_addr and the three control bits, and outputs accept.
- The top level holds the FSM, the header buffer, the AXIS muxing and the counters.

## Test plan
- Unicast match: mac_addr=02:00:00:00:00:01, 64-byte frame to that address → identical 64 bytes out, tlast on byte 63, pass_count=1.
- Mismatch: same frame to 02:00:00:00:00:02 with all control bits 0 → no m_axis_tvalid, s_axis_tready held 1 for 64 beats, drop_count=1.
- Broadcast/multicast: FF:..:FF with accept_broadcast=1 → passed; 01:00:5E:00:00:01 with accept_multicast=0 then 1 → dropped then passed.
- Runt: 4-byte frame with tlast on byte 3 → nothing out, drop_count+1; next valid frame passes intact.
- Backpressure: m_axis_tready toggled randomly 50% during REPLAY and PASS with tuser=1 on the last beat → byte-exact output, tuser=1 with tlast, no data loss.
- Reset mid-PASS, then saturation with CNT_WIDTH=2 and 5 accepted frames → after reset all outputs 0 and state IDLE; pass_count stops at 3.

Source files
------------

// File: rtl/eth_rx_mac_filter_pkg.sv
// rtl/eth_rx_mac_filter_pkg.sv - shared types and constants for the RX destination-MAC filter
package eth_rx_filter_pkg;

    typedef enum logic [2:0] {IDLE, HDR, REPLAY, PASS, DROP} state_t;

    localparam int          HDR_BYTES = 6;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_rx_mac_filter_if.sv
// rtl/eth_rx_mac_filter_if.sv - 8-bit byte stream bundle with tkeep/tuser/tlast
interface eth_rx_mac_filter_if;

    logic [7:0] tdata;
    logic       tkeep;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/eth_rx_mac_match.sv
// rtl/eth_rx_mac_match.sv - combinational accept decision for one destination address
module eth_rx_mac_match
    import eth_rx_filter_pkg::*;
(
    input  logic [47:0] dest,
    input  logic [47:0] mac_addr,
    input  logic        promisc,
    input  logic        accept_broadcast,
    input  logic        accept_multicast,
    output logic        accept
);

    // I/G bit is bit 0 of the first wire byte, which sits at dest[47:40]
    assign accept = promisc
                  | (dest == mac_addr)
                  | ((dest == MAC_BCAST) & accept_broadcast)
                  | (dest[40] & accept_multicast);

endmodule

// File: rtl/eth_rx_mac_filter.sv
// rtl/eth_rx_mac_filter.sv - RX destination-MAC filter; ETH_RX_FILTER_STATS_EN adds pass/drop counters
module eth_rx_mac_filter
    import eth_rx_filter_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clock125,
    input  logic                  reset,
    eth_rx_mac_filter_if.slave    s_axis,
    eth_rx_mac_filter_if.master   m_axis,
    input  logic [47:0]           mac_addr,
    input  logic                  promisc,
    input  logic                  accept_broadcast,
    input  logic                  accept_multicast,
    output logic [CNT_WIDTH-1:0]  pass_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam logic [2:0] HDR_LAST = 3'(HDR_BYTES - 1);

    state_t      state, state_next;
    logic        active;
    logic [7:0]  hdr [HDR_BYTES];
    logic [2:0]  hdr_idx;
    logic [47:0] dest;
    logic        accept, s_fire, hdr_last, runt, decide;

    assign s_fire   = s_axis.tvalid & s_axis.tready;
    assign hdr_last = (hdr_idx == HDR_LAST);
    assign runt     = s_fire & s_axis.tlast & ((state == IDLE) | (state == HDR));
    assign decide   = s_fire & ~s_axis.tlast & (state == HDR) & hdr_last;
    // the 6th byte is still on the bus in the decision cycle
    assign dest     = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], s_axis.tdata};

    eth_rx_mac_match u_match (
        .dest             (dest),
        .mac_addr         (mac_addr),
        .promisc          (promisc),
        .accept_broadcast (accept_broadcast),
        .accept_multicast (accept_multicast),
        .accept           (accept)
    );

    // active holds every output quiet until the first edge after reset release
    always_ff @(posedge clock125 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            active <= 1'b0;
        end else begin
            state  <= state_next;
            active <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (s_fire) state_next = s_axis.tlast ? IDLE : HDR;
            HDR:     if (runt) state_next = IDLE;
                     else if (decide) state_next = accept ? REPLAY : DROP;
            REPLAY:  if (m_axis.tready && hdr_last) state_next = PASS;
            PASS,
            DROP:    if (s_fire && s_axis.tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = 8'h00;
        m_axis.tkeep  = 1'b0;
        m_axis.tlast  = 1'b0;
        m_axis.tuser  = 1'b0;
        if (active) begin
            case (state)
                REPLAY: begin
                    m_axis.tvalid = 1'b1;
                    m_axis.tdata  = hdr[hdr_idx];
                    m_axis.tkeep  = 1'b1;
                end
                PASS: begin
                    s_axis.tready = m_axis.tready;
                    m_axis.tvalid = s_axis.tvalid;
                    m_axis.tdata  = s_axis.tdata;
                    m_axis.tkeep  = s_axis.tkeep;
                    m_axis.tlast  = s_axis.tlast;
                    m_axis.tuser  = s_axis.tuser;
                end
                default: s_axis.tready = 1'b1;
            endcase
        end
    end

    // hdr_idx is the write pointer while collecting and the read pointer while replaying
    always_ff @(posedge clock125 or posedge reset) begin
        if (reset) begin
            hdr_idx <= 3'd0;
            for (int i = 0; i < HDR_BYTES; i++) hdr[i] <= 8'h00;
        end else begin
            case (state)
                IDLE: if (s_fire) begin
                    hdr[0]  <= s_axis.tdata;
                    hdr_idx <= s_axis.tlast ? 3'd0 : 3'd1;
                end
                HDR: if (s_fire) begin
                    hdr[hdr_idx] <= s_axis.tdata;
                    hdr_idx      <= (s_axis.tlast || hdr_last) ? 3'd0 : hdr_idx + 3'd1;
                end
                REPLAY: if (m_axis.tready) hdr_idx <= hdr_last ? 3'd0 : hdr_idx + 3'd1;
                default: ;
            endcase
        end
    end

`ifdef ETH_RX_FILTER_STATS_EN
    logic pass_inc, drop_inc;
    assign pass_inc = decide & accept;
    assign drop_inc = runt | (decide & ~accept);

    always_ff @(posedge clock125 or posedge reset) begin
        if (reset) begin
            pass_count <= '0;
            drop_count <= '0;
        end else begin
            if (pass_inc && (pass_count != '1))
                pass_count <= pass_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (drop_inc && (drop_count != '1))
                drop_count <= drop_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end
`else
    assign pass_count = '0;
    assign drop_count = '0;
`endif

endmodule
